// File: rtl/hazard_unit_md.sv
// rtl/hazard_unit_md.sv - 5-stage pipeline hazard unit with internal mult/div busy tracker
// Combinational stall/forward decode plus a registered HI/LO busy FSM and a saturating stall counter.
module hazard_unit_md #(
  parameter int REG_W    = 5,
  parameter int MULT_LAT = 4,
  parameter int DIV_LAT  = 32,
  parameter int CNT_W    = 6,
  parameter int STAT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              BranchD,
  input  logic [REG_W-1:0]  RsD,
  input  logic [REG_W-1:0]  RtD,
  input  logic [REG_W-1:0]  RsE,
  input  logic [REG_W-1:0]  RtE,
  input  logic              MemtoRegE,
  input  logic              MemtoRegM,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic [REG_W-1:0]  WriteRegE,
  input  logic [REG_W-1:0]  WriteRegM,
  input  logic [REG_W-1:0]  WriteRegW,
  input  logic              mdStartE,
  input  logic              mdDivE,
  input  logic              mfReadD,
  input  logic              mdIssueD,
  input  logic              clrStats,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushE,
  output logic              ForwardAD,
  output logic              ForwardBD,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              mdBusy,
  output logic              mdDone,
  output logic [STAT_W-1:0] stallCycles
);

  typedef enum logic {IDLE, BUSY} md_state_t;

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT - 1);
  localparam logic [REG_W-1:0] ZERO_REG  = '0;

  md_state_t         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [STAT_W-1:0] stat_q, stat_d;

  logic lwstall, branchstall, mdstall, stall;
  logic e_hits_d, m_hits_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      stat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stat_q  <= stat_d;
    end
  end

  // A start seen while BUSY is dropped; the running operation keeps its count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mdDone  = 1'b0;
    case (state_q)
      IDLE: begin
        if (mdStartE) begin
          state_d = BUSY;
          cnt_d   = mdDivE ? DIV_LOAD : MULT_LOAD;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          mdDone  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mdBusy = (state_q == BUSY);

  always_comb begin
    lwstall  = MemtoRegE && (RtE != ZERO_REG) && ((RsD == RtE) || (RtD == RtE));
    e_hits_d = RegWriteE && (WriteRegE != ZERO_REG) && ((WriteRegE == RsD) || (WriteRegE == RtD));
    m_hits_d = MemtoRegM && (WriteRegM != ZERO_REG) && ((WriteRegM == RsD) || (WriteRegM == RtD));
    branchstall = BranchD && (e_hits_d || m_hits_d);
    // The done cycle is excluded so HI/LO readers proceed as the result lands.
    mdstall = (mfReadD || mdIssueD) && (mdStartE || (mdBusy && (cnt_q != '0)));
    stall   = lwstall || branchstall || mdstall;
  end

  assign StallF = stall;
  assign StallD = stall;
  assign FlushE = stall;

  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if ((RsE != ZERO_REG) && RegWriteM && (RsE == WriteRegM))      ForwardAE = 2'b10;
    else if ((RsE != ZERO_REG) && RegWriteW && (RsE == WriteRegW)) ForwardAE = 2'b01;
    if ((RtE != ZERO_REG) && RegWriteM && (RtE == WriteRegM))      ForwardBE = 2'b10;
    else if ((RtE != ZERO_REG) && RegWriteW && (RtE == WriteRegW)) ForwardBE = 2'b01;
  end

  assign ForwardAD = (RsD != ZERO_REG) && RegWriteM && (RsD == WriteRegM);
  assign ForwardBD = (RtD != ZERO_REG) && RegWriteM && (RtD == WriteRegM);

  always_comb begin
    stat_d = stat_q;
    if (clrStats)
      stat_d = '0;
    else if (stall && !(&stat_q))
      stat_d = stat_q + STAT_W'(1);
  end

  assign stallCycles = stat_q;

endmodule

// File: tb/tb_hazard_unit_md.sv
// tb/tb_hazard_unit_md.sv - directed self-checking bench for hazard_unit_md
// Inputs change just after negedge; outputs are sampled 1ns later, away from the rising edge.
module tb_hazard_unit_md;

  localparam int REG_W  = 5;
  localparam int STAT_W = 6;

  logic              clk;
  logic              rst_n;
  logic              BranchD;
  logic [REG_W-1:0]  RsD, RtD, RsE, RtE;
  logic              MemtoRegE, MemtoRegM;
  logic              RegWriteE, RegWriteM, RegWriteW;
  logic [REG_W-1:0]  WriteRegE, WriteRegM, WriteRegW;
  logic              mdStartE, mdDivE, mfReadD, mdIssueD, clrStats;
  logic              StallF, StallD, FlushE, ForwardAD, ForwardBD;
  logic [1:0]        ForwardAE, ForwardBE;
  logic              mdBusy, mdDone;
  logic [STAT_W-1:0] stallCycles;

  int total = 0;
  int bad   = 0;

  hazard_unit_md #(
    .REG_W(REG_W), .MULT_LAT(4), .DIV_LAT(32), .CNT_W(6), .STAT_W(STAT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .BranchD(BranchD),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .mdStartE(mdStartE), .mdDivE(mdDivE), .mfReadD(mfReadD), .mdIssueD(mdIssueD),
    .clrStats(clrStats),
    .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .mdBusy(mdBusy), .mdDone(mdDone), .stallCycles(stallCycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    BranchD = 0; RsD = 0; RtD = 0; RsE = 0; RtE = 0;
    MemtoRegE = 0; MemtoRegM = 0; RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
    WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
    mdStartE = 0; mdDivE = 0; mfReadD = 0; mdIssueD = 0; clrStats = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    #1;
    chk("rst_busy", mdBusy, 0);
    chk("rst_done", mdDone, 0);
    chk("rst_stat", stallCycles, 0);
    chk("rst_stall", StallD, 0);
    chk("rst_fwdae", ForwardAE, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // load-use
    MemtoRegE = 1; RtE = 8; RsD = 8;
    #1;
    chk("lw_stallf", StallF, 1);
    chk("lw_stalld", StallD, 1);
    chk("lw_flushe", FlushE, 1);
    RtE = 0; RsD = 0;
    #1;
    chk("lw_zero_reg", StallD, 0);
    RtE = 8; RsD = 3; RtD = 8;
    #1;
    chk("lw_rt_path", StallD, 1);
    idle_inputs();

    // forwarding priority
    RsE = 3; WriteRegM = 3; WriteRegW = 3; RegWriteM = 1; RegWriteW = 1;
    #1;
    chk("fwd_ae_m", ForwardAE, 2'b10);
    RegWriteM = 0;
    #1;
    chk("fwd_ae_w", ForwardAE, 2'b01);
    RsE = 0;
    #1;
    chk("fwd_ae_zero", ForwardAE, 2'b00);
    RtE = 3;
    #1;
    chk("fwd_be_w", ForwardBE, 2'b01);
    RegWriteM = 1; RsD = 3; RtD = 4;
    #1;
    chk("fwd_ad", ForwardAD, 1);
    chk("fwd_bd_miss", ForwardBD, 0);
    RsD = 0;
    #1;
    chk("fwd_ad_zero", ForwardAD, 0);
    idle_inputs();

    // branch
    BranchD = 1; RegWriteE = 1; WriteRegE = 5; RtD = 5;
    #1;
    chk("br_e_stall", StallD, 1);
    WriteRegE = 0; RtD = 0;
    #1;
    chk("br_zero_reg", StallD, 0);
    RegWriteE = 0; MemtoRegM = 1; WriteRegM = 5; RsD = 5;
    #1;
    chk("br_m_stall", StallD, 1);
    idle_inputs();

    clrStats = 1;
    @(negedge clk);
    clrStats = 0;
    #1;
    chk("clr_stat0", stallCycles, 0);

    // multiply, LAT=4
    mdStartE = 1; mdDivE = 0; mfReadD = 1;
    #1;
    chk("mul_t_stall", StallD, 1);
    chk("mul_t_busy", mdBusy, 0);
    @(negedge clk);
    mdStartE = 0;
    #1;
    chk("mul_t1_busy", mdBusy, 1);
    chk("mul_t1_stall", StallD, 1);
    for (int i = 2; i <= 3; i++) begin
      @(negedge clk); #1;
      chk("mul_mid_stall", StallD, 1);
      chk("mul_mid_done", mdDone, 0);
    end
    @(negedge clk); #1;
    chk("mul_t4_done", mdDone, 1);
    chk("mul_t4_stall", StallD, 0);
    chk("mul_t4_busy", mdBusy, 1);
    @(negedge clk); #1;
    chk("mul_t5_busy", mdBusy, 0);
    chk("mul_t5_done", mdDone, 0);
    chk("mul_stat", stallCycles, 4);
    idle_inputs();

    // divide, LAT=32, with an ignored start mid-operation
    clrStats = 1;
    @(negedge clk);
    clrStats = 0;
    mdStartE = 1; mdDivE = 1; mdIssueD = 1;
    #1;
    chk("div_t_stall", StallD, 1);
    for (int i = 1; i <= 31; i++) begin
      @(negedge clk);
      mdStartE = (i == 5);
      mdDivE   = (i != 5);
      #1;
      chk("div_mid_stall", StallD, 1);
      chk("div_mid_done", mdDone, 0);
    end
    mdStartE = 0;
    @(negedge clk); #1;
    chk("div_t32_done", mdDone, 1);
    chk("div_t32_stall", StallD, 0);
    @(negedge clk); #1;
    chk("div_t33_busy", mdBusy, 0);
    chk("div_stat", stallCycles, 32);

    // clear wins over a simultaneous stall increment
    mdIssueD = 0; MemtoRegE = 1; RtE = 8; RsD = 8; clrStats = 1;
    @(negedge clk); #1;
    chk("clr_wins", stallCycles, 0);
    clrStats = 0;
    for (int i = 0; i < 70; i++) @(negedge clk);
    #1;
    chk("stat_sat", stallCycles, 63);
    @(negedge clk); #1;
    chk("stat_hold", stallCycles, 63);
    idle_inputs();

    // reset mid-divide at cnt=10
    mdStartE = 1; mdDivE = 1;
    @(negedge clk);
    mdStartE = 0;
    for (int i = 2; i <= 22; i++) @(negedge clk);
    #1;
    chk("rstmid_busy_pre", mdBusy, 1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_busy", mdBusy, 0);
    chk("rstmid_done", mdDone, 0);
    chk("rstmid_stat", stallCycles, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rstrel_busy", mdBusy, 0);
    @(negedge clk); #1;
    chk("rstrel_busy2", mdBusy, 0);
    chk("rstrel_done2", mdDone, 0);
    mdStartE = 1; mdDivE = 0;
    @(negedge clk);
    mdStartE = 0;
    #1;
    chk("restart_busy", mdBusy, 1);
    chk("restart_done0", mdDone, 0);
    for (int i = 2; i <= 4; i++) @(negedge clk);
    #1;
    chk("restart_done", mdDone, 1);
    @(negedge clk); #1;
    chk("restart_idle", mdBusy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

endmodule
